mips_soc_top: RTL and testbench
===============================

MIPS_SOC_TOP -- requirements
Module: mips_soc_top

Interface
REQ-001 SHALL have a single clock and a reset that is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge system clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-004 SHALL have port: writedata  output  32  register rt value presented to the data bus.
REQ-005 SHALL have port: dataadr  output  32  ALU result used as the data address.
REQ-006 SHALL have port: memwrite  output  1  store strobe for the current instruction.
REQ-007 SHALL have port: pc  output  32  current program counter.
REQ-008 SHALL have port: instr  output  32  instruction word at pc.
REQ-009 SHALL have port: readdata  output  32  data-bus read value: RAM or I/O.
REQ-010 SHALL have port: switches  input  8  board switches; [5:0] is the display select, [7:6] is readable by software only.
REQ-011 SHALL have port: dispDat  output  32  selected display value.

Function
REQ-012 SHALL be a single-cycle MIPS32 core: one instruction per clk; pc and register file update on the rising edge.
REQ-013 SHALL support add, sub, and, or, slt (R-type), addi, lw, sw, beq and j; any other opcode executes as a no-op, with pc+4.
REQ-014 Instruction and ALU arithmetic SHALL follow these rules:
- addi, lw and sw sign-extend imm16.
- beq target = pc+4+(sext(imm16)<<2).
- j target = {pc+4[31:28], imm26, 2'b00}.
- Arithmetic is 32-bit two's-complement wrap-around with no overflow trap.
REQ-015 Register $0 SHALL read as 0, and writes to it SHALL be ignored.
REQ-016 Instruction memory SHALL be a 64-word ROM indexed by pc[7:2], with a combinational read.
REQ-017 Data RAM SHALL be 64 words indexed by dataadr[7:2], with a combinational read and a write on the rising edge when memwrite=1.
REQ-018 Memory-mapped I/O SHALL decode as follows:
- dataadr 0xFFFFFFF8 read returns {24'b0, switches}.
- dataadr 0xFFFFFFFC sw loads the 32-bit display register; RAM is not written.
- dataadr 0xFFFFFFFC lw returns the display register.
REQ-019 dispDat SHALL be selected combinationally by switches[5:0]:
- 0: pc.
- 1: instr.
- 2: display register.
- Any other value: 32'd0.
REQ-020 The ROM program SHALL compute the factorials 1!, 2!, 3! and 4! by repeated addition.
REQ-021 After each factorial is computed, the program SHALL store it to the display register.
REQ-022 After storing 24, the program SHALL halt by jumping to itself.
REQ-023 The display register SHALL only ever hold values from {0, 1, 2, 6, 24}, in non-decreasing order.
REQ-024 The display value 24 SHALL be reached within 500 clk cycles after reset release.
REQ-025 A switches change SHALL affect dispDat in the same cycle, without any clock delay.

Reset
REQ-026 While reset=0 the design SHALL hold the following state:
- pc=0.
- Display register=0.
- All 32 registers=0.
REQ-027 RAM contents SHALL be don't-care after reset.
REQ-028 Reset asserted mid-program SHALL immediately return pc to 0 and clear the display register, without waiting for clk.
REQ-029 After reset release, the program SHALL restart from instruction 0 on the next rising edge.

Structure
REQ-030 A shared package SHALL hold the following:
- Opcode and funct constants.
- ALU control encodings.
- The I/O addresses 0xFFFFFFF8 and 0xFFFFFFFC.
- The display-select codes 0, 1 and 2.
REQ-031 The single natural sub-module SHALL be mips_core (controller, datapath, register file and ALU).
REQ-032 mips_soc_top SHALL hold the following, outside mips_core:
- Instruction ROM.
- Data RAM.
- I/O decode.
- Display register.
- dispDat mux.

Verification
REQ-033 Scenario: hold reset=0 for 2 cycles with switches=0 -> pc=0 and dispDat=0; release reset -> pc advances by 4 each cycle until the first branch.
REQ-034 Scenario: switches=2 from reset release, sampled on each falling edge -> dispDat takes only the values 0, 1, 2, 6, 24, in non-decreasing order.
REQ-035 Scenario (continuing REQ-034): dispDat reaches 24 within 500 cycles, and pc then stays constant at the halt address.
REQ-036 Scenario: switches=1 -> dispDat equals instr every cycle; switches=63 -> dispDat=0.
REQ-037 Scenario: switches=0xA5 with the program reading 0xFFFFFFF8 -> readdata=0x000000A5.
REQ-038 Scenario: a sw to 0xFFFFFFFC shows memwrite=1 and dataadr=0xFFFFFFFC, and a subsequent RAM read of word 63 is unchanged.
REQ-039 Scenario: drop reset to 0 asynchronously mid-program (between clk edges) -> pc=0 and display register=0 immediately; after re-release, the display sequence 1, 2, 6, 24 repeats.

Source files
------------

// File: rtl/mips_soc_pkg.sv
// Shared encodings for the single-cycle MIPS SoC: opcodes, funct codes, ALU
// control, memory-mapped I/O addresses and display-select codes.
package mips_soc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    localparam logic [31:0] IO_SWITCH_ADR = 32'hFFFF_FFF8;
    localparam logic [31:0] IO_DISP_ADR   = 32'hFFFF_FFFC;

    localparam logic [5:0] DSEL_PC    = 6'd0;
    localparam logic [5:0] DSEL_INSTR = 6'd1;
    localparam logic [5:0] DSEL_DISP  = 6'd2;

    function automatic logic [31:0] alu_eval(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input alu_ctrl_e   ctl);
        logic [31:0] res;
        case (ctl)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_SLT: res = {31'd0, ($signed(a) < $signed(b))};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_core.sv
// Single-cycle MIPS32 core: decoder, register file, ALU and next-pc logic.
// Memories live outside; one instruction retires per clk.
module mips_core
    import mips_soc_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_readdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_aluout,
    output logic [31:0] o_writedata,
    output logic        o_memwrite
);

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_wa;
    logic        w_shamt_zero;
    logic        w_regwrite;
    logic        w_alusrc;
    logic        w_regdst;
    logic        w_memtoreg;
    logic        w_memwrite;
    logic        w_branch;
    logic        w_jump;
    alu_ctrl_e   w_aluctl;
    logic [31:0] w_sext;
    logic [31:0] w_rsval;
    logic [31:0] w_rtval;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [31:0] w_wd;
    logic [31:0] w_pc4;
    logic [31:0] w_pcnext;

    assign w_op         = i_instr[31:26];
    assign w_rs         = i_instr[25:21];
    assign w_rt         = i_instr[20:16];
    assign w_rd         = i_instr[15:11];
    assign w_funct      = i_instr[5:0];
    assign w_shamt_zero = (i_instr[10:6] == 5'd0);
    assign w_sext       = {{16{i_instr[15]}}, i_instr[15:0]};

    // Unsupported opcodes/functs leave every enable low, so they retire as no-ops.
    always_comb begin
        w_regwrite = 1'b0;
        w_alusrc   = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_aluctl   = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                if (w_shamt_zero) begin
                    case (w_funct)
                        FN_ADD: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctl = ALU_ADD; end
                        FN_SUB: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctl = ALU_SUB; end
                        FN_AND: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctl = ALU_AND; end
                        FN_OR:  begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctl = ALU_OR;  end
                        FN_SLT: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctl = ALU_SLT; end
                        default: ;
                    endcase
                end
            end
            OP_ADDI: begin w_regwrite = 1'b1; w_alusrc = 1'b1; end
            OP_LW:   begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_memtoreg = 1'b1; end
            OP_SW:   begin w_alusrc = 1'b1; w_memwrite = 1'b1; end
            OP_BEQ:  begin w_branch = 1'b1; w_aluctl = ALU_SUB; end
            OP_J:    w_jump = 1'b1;
            default: ;
        endcase
    end

    assign w_rsval = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rtval = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
    assign w_b     = w_alusrc ? w_sext : w_rtval;
    assign w_alu   = alu_eval(w_rsval, w_b, w_aluctl);
    assign w_wa    = w_regdst ? w_rd : w_rt;
    assign w_wd    = w_memtoreg ? i_readdata : w_alu;
    assign w_pc4   = r_pc + 32'd4;

    always_comb begin
        w_pcnext = w_pc4;
        if (w_jump)
            w_pcnext = {w_pc4[31:28], i_instr[25:0], 2'b00};
        else if (w_branch && (w_alu == 32'd0))
            w_pcnext = w_pc4 + {w_sext[29:0], 2'b00};
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= 32'd0;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'd0;
        end else begin
            r_pc <= w_pcnext;
            if (w_regwrite && (w_wa != 5'd0))
                r_regs[w_wa] <= w_wd;
        end
    end

    assign o_pc        = r_pc;
    assign o_aluout    = w_alu;
    assign o_writedata = w_rtval;
    assign o_memwrite  = w_memwrite;

endmodule

// File: rtl/mips_soc_top.sv
// MIPS SoC: core plus factorial ROM, data RAM, switch/display I/O decode and
// the switch-selected display mux.
module mips_soc_top
    import mips_soc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  switches,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] readdata,
    output logic [31:0] dispDat
);

    logic [31:0] r_ram [0:63];
    logic [31:0] r_disp;
    logic [31:0] w_instr;
    logic        w_io_sw;
    logic        w_io_disp;
    logic        w_ram_we;

    mips_core u_core (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_instr     (w_instr),
        .i_readdata  (readdata),
        .o_pc        (pc),
        .o_aluout    (dataadr),
        .o_writedata (writedata),
        .o_memwrite  (memwrite)
    );

    // Factorials 1!..4!: $2 = fact, $3 = i, $4 = limit, inner loop adds fact i times.
    always_comb begin
        case (pc[7:2])
            6'd0:  w_instr = 32'h2007005A; // addi $7,$0,0x5A
            6'd1:  w_instr = 32'hAC0700FC; // sw   $7,252($0)
            6'd2:  w_instr = 32'h8C06FFF8; // lw   $6,-8($0)
            6'd3:  w_instr = 32'h00075022; // sub  $10,$0,$7
            6'd4:  w_instr = 32'h01475824; // and  $11,$10,$7
            6'd5:  w_instr = 32'h01476025; // or   $12,$10,$7
            6'd6:  w_instr = 32'h0147682A; // slt  $13,$10,$7
            6'd7:  w_instr = 32'h00EA702A; // slt  $14,$7,$10
            6'd8:  w_instr = 32'h20020001; // addi $2,$0,1
            6'd9:  w_instr = 32'h20030001; // addi $3,$0,1
            6'd10: w_instr = 32'h20040005; // addi $4,$0,5
            6'd11: w_instr = 32'h00002820; // loop: add $5,$0,$0
            6'd12: w_instr = 32'h00004020; // add  $8,$0,$0
            6'd13: w_instr = 32'h00A22820; // mul: add $5,$5,$2
            6'd14: w_instr = 32'h21080001; // addi $8,$8,1
            6'd15: w_instr = 32'h11030001; // beq  $8,$3,+1
            6'd16: w_instr = 32'h0800000D; // j    mul
            6'd17: w_instr = 32'h00A01020; // add  $2,$5,$0
            6'd18: w_instr = 32'hAC02FFFC; // sw   $2,-4($0)
            6'd19: w_instr = 32'h8C0900FC; // lw   $9,252($0)
            6'd20: w_instr = 32'h20630001; // addi $3,$3,1
            6'd21: w_instr = 32'h10640001; // beq  $3,$4,+1
            6'd22: w_instr = 32'h0800000B; // j    loop
            6'd23: w_instr = 32'h08000017; // halt: j halt
            default: w_instr = 32'h00000000;
        endcase
    end

    assign instr     = w_instr;
    assign w_io_sw   = (dataadr == IO_SWITCH_ADR);
    assign w_io_disp = (dataadr == IO_DISP_ADR);
    assign w_ram_we  = memwrite && !w_io_disp;

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[dataadr[7:2]] <= writedata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_disp <= 32'd0;
        else if (memwrite && w_io_disp)
            r_disp <= writedata;
    end

    always_comb begin
        if (w_io_sw)
            readdata = {24'd0, switches};
        else if (w_io_disp)
            readdata = r_disp;
        else
            readdata = r_ram[dataadr[7:2]];
    end

    always_comb begin
        case (switches[5:0])
            DSEL_PC:    dispDat = pc;
            DSEL_INSTR: dispDat = w_instr;
            DSEL_DISP:  dispDat = r_disp;
            default:    dispDat = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mips_soc_top.sv
// Directed bench for mips_soc_top: reset, start-up sequence, factorial display
// run, halt, display-select mux and asynchronous mid-program reset.
module tb_mips_soc_top;

    logic        clk;
    logic        reset;
    logic [7:0]  switches;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] readdata;
    logic [31:0] dispDat;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] HALT_PC    = 32'd92;
    localparam logic [31:0] HALT_INSTR = 32'h08000017;

    mips_soc_top dut (
        .clk       (clk),
        .reset     (reset),
        .switches  (switches),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite),
        .pc        (pc),
        .instr     (instr),
        .readdata  (readdata),
        .dispDat   (dispDat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        switches = 8'h00;
        step();
        step();
        checks++;
        if (pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0);
        end
        checks++;
        if (dispDat !== 32'd0) begin
            failures++;
            $display("FAIL reset_disp got=%h exp=%h", dispDat, 32'd0);
        end
        checks++;
        if (instr !== 32'h2007005A) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=%h", instr, 32'h2007005A);
        end
    endtask

    task automatic test_startup();
        logic [31:0] exp_adr [0:7];
        exp_adr[0] = 32'h0000005A;
        exp_adr[1] = 32'h000000FC;
        exp_adr[2] = 32'hFFFFFFF8;
        exp_adr[3] = 32'hFFFFFFA6;
        exp_adr[4] = 32'h00000002;
        exp_adr[5] = 32'hFFFFFFFE;
        exp_adr[6] = 32'h00000001;
        exp_adr[7] = 32'h00000000;
        switches = 8'hA5;
        reset    = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL startup_pc step=%0d got=%h exp=%h", k, pc, 32'(4 * k));
            end
            if (k < 8) begin
                checks++;
                if (dataadr !== exp_adr[k]) begin
                    failures++;
                    $display("FAIL startup_alu step=%0d got=%h exp=%h", k, dataadr, exp_adr[k]);
                end
            end
            if (k == 1) begin
                checks++;
                if (memwrite !== 1'b1 || writedata !== 32'h5A) begin
                    failures++;
                    $display("FAIL startup_sw got=%b/%h exp=1/%h", memwrite, writedata, 32'h5A);
                end
            end
            if (k == 2) begin
                checks++;
                if (readdata !== 32'h000000A5) begin
                    failures++;
                    $display("FAIL switch_read got=%h exp=%h", readdata, 32'h000000A5);
                end
            end
            step();
        end
    endtask

    // Assumes reset was just released on a negedge with switches selecting the display.
    task automatic test_display_sequence(input string tag);
        logic [31:0] exp_seq [0:3];
        logic [31:0] prev;
        int          idx;
        bit          done;
        exp_seq[0] = 32'd1;
        exp_seq[1] = 32'd2;
        exp_seq[2] = 32'd6;
        exp_seq[3] = 32'd24;
        prev = 32'd0;
        idx  = 0;
        done = 1'b0;
        checks++;
        if (dispDat !== 32'd0) begin
            failures++;
            $display("FAIL %s_disp_start got=%h exp=%h", tag, dispDat, 32'd0);
        end
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            if (pc == 32'd72 && idx < 4) begin
                checks++;
                if (memwrite !== 1'b1 || dataadr !== 32'hFFFFFFFC || writedata !== exp_seq[idx]) begin
                    failures++;
                    $display("FAIL %s_disp_store got=%b/%h/%h exp=1/fffffffc/%h",
                             tag, memwrite, dataadr, writedata, exp_seq[idx]);
                end
            end
            if (pc == 32'd76) begin
                checks++;
                if (readdata !== 32'h5A) begin
                    failures++;
                    $display("FAIL %s_ram63_kept got=%h exp=%h", tag, readdata, 32'h5A);
                end
            end
            if (dispDat !== prev) begin
                checks++;
                if (idx > 3 || dispDat !== exp_seq[idx]) begin
                    failures++;
                    $display("FAIL %s_disp_order idx=%0d got=%h exp=%h",
                             tag, idx, dispDat, exp_seq[idx > 3 ? 3 : idx]);
                    done = 1'b1;
                end else begin
                    if (dispDat == 32'd24)
                        done = 1'b1;
                    idx++;
                end
                prev = dispDat;
            end
            if (!done)
                step();
        end
        checks++;
        if (!done || idx != 4) begin
            failures++;
            $display("FAIL %s_disp_reach24 got_idx=%0d disp=%h exp_idx=4 disp=24", tag, idx, dispDat);
        end
    endtask

    task automatic test_display_run();
        reset    = 1'b0;
        switches = 8'd2;
        step();
        reset = 1'b1;
        #1;
        test_display_sequence("run1");
    endtask

    task automatic test_halt();
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (pc !== HALT_PC) begin
                failures++;
                $display("FAIL halt_pc cyc=%0d got=%h exp=%h", k, pc, HALT_PC);
            end
            step();
        end
    endtask

    task automatic test_disp_select();
        logic [7:0]  sel [0:5];
        logic [31:0] exp [0:5];
        sel[0] = 8'd0;  exp[0] = HALT_PC;
        sel[1] = 8'd1;  exp[1] = HALT_INSTR;
        sel[2] = 8'd2;  exp[2] = 32'd24;
        sel[3] = 8'd63; exp[3] = 32'd0;
        sel[4] = 8'd3;  exp[4] = 32'd0;
        sel[5] = 8'hC2; exp[5] = 32'd24;
        for (int k = 0; k < 6; k++) begin
            switches = sel[k];
            #1;
            checks++;
            if (dispDat !== exp[k]) begin
                failures++;
                $display("FAIL disp_select sel=%h got=%h exp=%h", sel[k], dispDat, exp[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        reset    = 1'b0;
        switches = 8'd2;
        step();
        reset = 1'b1;
        for (int k = 0; k < 40; k++) step();
        checks++;
        if (dispDat == 32'd0 || dispDat > 32'd24) begin
            failures++;
            $display("FAIL async_pre_disp got=%h exp=1..24", dispDat);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (pc !== 32'd0) begin
            failures++;
            $display("FAIL async_pc got=%h exp=%h", pc, 32'd0);
        end
        checks++;
        if (dispDat !== 32'd0) begin
            failures++;
            $display("FAIL async_disp got=%h exp=%h", dispDat, 32'd0);
        end
        step();
        reset = 1'b1;
        #1;
        test_display_sequence("rerun");
    endtask

    initial begin
        test_reset();
        test_startup();
        test_display_run();
        test_halt();
        test_disp_select();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
